// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : TinyMIPS instruction-fetch stage. Owns the PC, runs the
//               instruction ROM request/ready handshake, holds a fetched word
//               while IF is stalled, defers a taken branch past its delay
//               slot and drains an in-flight request after a flush.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_current_stage,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        branch_flag,
    input  logic [31:0] branch_addr,
    output logic        rom_en,
    output logic [31:0] rom_addr,
    input  logic        rom_ready,
    input  logic [31:0] rom_rdata,
    output logic        stall_request,
    output logic [31:0] pc_out,
    output logic [31:0] inst_out,
    output logic        valid_out
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_buf_inst;
    logic [31:0] w_buf_inst_nxt;
    logic        r_pend_valid;
    logic        w_pend_valid_nxt;
    // Holds the deferred branch target; while in S_DROP (where no branch can
    // be pending) it instead holds the address of the abandoned request.
    logic [31:0] r_pend_addr;
    logic [31:0] w_pend_addr_nxt;
    logic        w_avail;
    logic        w_handoff;

    // An instruction is available when buffered, or when the ROM completes now.
    always_comb begin
        w_avail   = (r_state == S_HOLD) || ((r_state == S_REQ) && rom_ready);
        w_handoff = w_avail && !stall_current_stage;
    end

    // Outputs; reset forces the quiescent values regardless of the state regs.
    always_comb begin
        rom_en        = 1'b0;
        rom_addr      = r_pc;
        stall_request = 1'b0;
        valid_out     = 1'b0;
        inst_out      = 32'd0;
        pc_out        = RESET_PC;
        if (!rst) begin
            rom_en        = (r_state == S_REQ) || (r_state == S_DROP);
            rom_addr      = (r_state == S_DROP) ? r_pend_addr : r_pc;
            stall_request = !w_avail;
            valid_out     = w_avail && !flush;
            inst_out      = (r_state == S_HOLD) ? r_buf_inst : rom_rdata;
            pc_out        = r_pc;
        end
    end

    // Next-state and next-register computation; flush has top priority.
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_buf_inst_nxt   = r_buf_inst;
        w_pend_valid_nxt = r_pend_valid;
        w_pend_addr_nxt  = r_pend_addr;
        if (flush) begin
            w_pc_nxt         = flush_pc;
            w_pend_valid_nxt = 1'b0;
            if ((r_state == S_REQ) && !rom_ready) begin
                // Remember the request still in flight so rom_addr stays stable.
                w_pend_addr_nxt = r_pc;
                w_state_nxt     = S_DROP;
            end else if (r_state == S_DROP) begin
                w_state_nxt = S_DROP;
            end else begin
                w_state_nxt = S_REQ;
            end
        end else if (r_state == S_DROP) begin
            // Branches here are superseded by the flush that caused the drop.
            if (rom_ready) begin
                w_state_nxt = S_REQ;
            end
        end else if (w_handoff) begin
            if (r_pend_valid) begin
                w_pc_nxt = r_pend_addr;
            end else if (branch_flag) begin
                w_pc_nxt = branch_addr;
            end else begin
                w_pc_nxt = r_pc + 32'd4;
            end
            w_pend_valid_nxt = 1'b0;
            w_state_nxt      = S_REQ;
        end else begin
            if (branch_flag) begin
                // Current instruction is the delay slot; redirect after it.
                w_pend_addr_nxt  = branch_addr;
                w_pend_valid_nxt = 1'b1;
            end
            if ((r_state == S_REQ) && rom_ready) begin
                w_buf_inst_nxt = rom_rdata;
                w_state_nxt    = S_HOLD;
            end
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_REQ;
            r_pc         <= RESET_PC;
            r_buf_inst   <= 32'd0;
            r_pend_valid <= 1'b0;
            r_pend_addr  <= 32'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_buf_inst   <= w_buf_inst_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_pend_addr  <= w_pend_addr_nxt;
        end
    end

endmodule
`default_nettype wire
